// File: rtl/uop_engine_arbiter_pkg.sv
// Shared types for the uop engine arbiter.
//   ibuffer_t        - instruction-buffer entry carried as macro-op / uop payload
//   uop_arb_state_e  - arbiter FSM state, exported for trace printing
//   log2up()         - index width helper that never returns 0
package uop_engine_arbiter_pkg;

  typedef struct packed {
    logic [7:0]  op;
    logic [3:0]  wid;
    logic [19:0] imm;
  } ibuffer_t;

  typedef enum logic [0:0] {
    UOP_ARB_IDLE   = 1'b0,
    UOP_ARB_ACTIVE = 1'b1
  } uop_arb_state_e;

  function automatic int unsigned log2up(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uop_engine_arbiter_if.sv
// Handshake bundle between the per-warp ibuffers, the arbiter and the shared
// uop expansion engine.
//   req_valid/req_data/req_ready : macro-op requests, one lane per warp
//   eng_start/eng_data/eng_next  : arbiter -> engine control
//   eng_uop/eng_done             : engine -> arbiter current uop
//   out_valid/out_data/out_ready : uop stream back to the owning warp
// master: the warps + engine side; slave: the arbiter.
interface uop_engine_arbiter_if
  import uop_engine_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned DATA_WIDTH = $bits(ibuffer_t)
);

  logic [NUM_REQS-1:0]                 req_valid;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQS-1:0]                 req_ready;

  logic                                eng_start;
  logic [DATA_WIDTH-1:0]               eng_data;
  logic                                eng_next;
  logic [DATA_WIDTH-1:0]               eng_uop;
  logic                                eng_done;

  logic [NUM_REQS-1:0]                 out_valid;
  logic [DATA_WIDTH-1:0]               out_data;
  logic [NUM_REQS-1:0]                 out_ready;

  modport master (
    output req_valid, req_data,
    input  req_ready,
    input  eng_start, eng_data, eng_next,
    output eng_uop, eng_done,
    input  out_valid, out_data,
    output out_ready
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready,
    output eng_start, eng_data, eng_next,
    input  eng_uop, eng_done,
    output out_valid, out_data,
    input  out_ready
  );

endinterface

// File: rtl/uop_rr_picker.sv
// Combinational circular priority encoder.
//   req       - request vector
//   ptr       - index searched first; search wraps past NUM_REQS-1 to 0
//   grant     - first requesting index at or after ptr (0 when none)
//   any_valid - at least one request bit is set
module uop_rr_picker
  import uop_engine_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4
) (
  input  logic [NUM_REQS-1:0]         req,
  input  logic [log2up(NUM_REQS)-1:0] ptr,
  output logic [log2up(NUM_REQS)-1:0] grant,
  output logic                        any_valid
);

  localparam int unsigned IdxW = log2up(NUM_REQS);

  logic [IdxW-1:0] idx;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      idx = IdxW'((32'(ptr) + k) % NUM_REQS);
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        grant     = idx;
      end
    end
  end

endmodule

// File: rtl/uop_engine_arbiter.sv
// Shares one uop expansion engine among NUM_REQS warps. A round-robin grant
// locks the engine to one warp for a whole macro-op; the generated uops are
// streamed back to that warp, and the engine is released after the last one.
//   clk, reset_n      - clock, asynchronous active-low reset
//   bus (slave)       - request, engine and uop-stream handshakes
//   owner             - warp currently (or most recently) holding the engine
//   busy              - engine locked to owner
//   perf_macro_ops    - completed macro-ops, wrapping
//   perf_stall_cycles - locked cycles with the owner's out_ready low, wrapping
module uop_engine_arbiter
  import uop_engine_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned DATA_WIDTH = $bits(ibuffer_t)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  uop_engine_arbiter_if.slave         bus,
  output logic [log2up(NUM_REQS)-1:0] owner,
  output logic                        busy,
  output logic [31:0]                 perf_macro_ops,
  output logic [31:0]                 perf_stall_cycles
);

  localparam int unsigned IdxW = log2up(NUM_REQS);

  uop_arb_state_e        state_q, state_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [31:0]           macro_ops_q, stall_cycles_q;

  logic [IdxW-1:0]       grant;
  logic                  any_valid;

  logic                  eng_start_c;
  logic                  eng_next_c;
  logic [DATA_WIDTH-1:0] eng_data_c;
  logic [NUM_REQS-1:0]   out_valid_c;
  logic [NUM_REQS-1:0]   req_ready_c;
  logic                  macro_inc;
  logic                  stall_inc;

  uop_rr_picker #(
    .NUM_REQS (NUM_REQS)
  ) u_picker (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .any_valid (any_valid)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    eng_start_c = 1'b0;
    eng_next_c  = 1'b0;
    eng_data_c  = bus.req_data[owner_q];
    out_valid_c = '0;
    req_ready_c = '0;
    macro_inc   = 1'b0;
    stall_inc   = 1'b0;

    unique case (state_q)
      UOP_ARB_IDLE: begin
        // The engine latches its macro-op on the start pulse, so the granted
        // payload must be on eng_data in this same cycle.
        eng_data_c = bus.req_data[grant];
        if (any_valid) begin
          eng_start_c = 1'b1;
          owner_d     = grant;
          state_d     = UOP_ARB_ACTIVE;
        end
      end

      UOP_ARB_ACTIVE: begin
        out_valid_c[owner_q] = 1'b1;
        // Advance only on a handshake so a stalled uop stays presented.
        eng_next_c           = bus.out_ready[owner_q];
        stall_inc            = !bus.out_ready[owner_q];
        if (bus.out_ready[owner_q] && bus.eng_done) begin
          req_ready_c[owner_q] = 1'b1;
          macro_inc            = 1'b1;
          state_d              = UOP_ARB_IDLE;
          rr_ptr_d             = (owner_q == IdxW'(NUM_REQS - 1)) ? '0 : owner_q + 1'b1;
        end
      end

      default: begin
        state_d = UOP_ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= UOP_ARB_IDLE;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      macro_ops_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      if (macro_inc) begin
        macro_ops_q <= macro_ops_q + 32'd1;
      end
      if (stall_inc) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  // The start pulse is purely combinational from IDLE, so it is masked by
  // reset to keep the engine quiet while reset is held with requests pending.
  assign bus.eng_start = eng_start_c & reset_n;
  assign bus.eng_next  = eng_next_c;
  assign bus.eng_data  = eng_data_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = bus.eng_uop;
  assign bus.req_ready = req_ready_c;

  assign owner             = owner_q;
  assign busy              = (state_q == UOP_ARB_ACTIVE);
  assign perf_macro_ops    = macro_ops_q;
  assign perf_stall_cycles = stall_cycles_q;

  // The owner must keep its macro-op pending until the last uop is accepted.
  owner_holds_req : assert property (
    @(posedge clk) disable iff (!reset_n)
    (state_q == UOP_ARB_ACTIVE) |-> bus.req_valid[owner_q]
  );

endmodule

// File: tb/tb_uop_engine_arbiter.sv
// Scoreboard bench for uop_engine_arbiter with a stub expansion engine.
module tb_uop_engine_arbiter;
  import uop_engine_arbiter_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uop_engine_arbiter_if #(.NUM_REQS(N), .DATA_WIDTH(DW)) bus ();

  logic [1:0]  owner;
  logic        busy;
  logic [31:0] perf_macro_ops;
  logic [31:0] perf_stall_cycles;

  uop_engine_arbiter #(
    .NUM_REQS   (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .bus               (bus),
    .owner             (owner),
    .busy              (busy),
    .perf_macro_ops    (perf_macro_ops),
    .perf_stall_cycles (perf_stall_cycles)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub engine: uop count in macro-op bits [3:0]; uop k = macro-op + (k << 16).
  logic [3:0]  e_idx;
  logic [3:0]  e_cnt;
  logic [31:0] e_base;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_idx  <= 4'd0;
      e_cnt  <= 4'd0;
      e_base <= 32'd0;
    end else if (bus.eng_start) begin
      e_idx  <= 4'd0;
      e_cnt  <= bus.eng_data[3:0];
      e_base <= bus.eng_data;
    end else if (bus.eng_next) begin
      e_idx <= e_idx + 4'd1;
    end
  end
  assign bus.eng_uop  = e_base + {12'h0, e_idx, 16'h0};
  assign bus.eng_done = (e_idx == e_cnt - 4'd1);

  typedef struct {
    int          warp;
    logic [31:0] data;
    bit          last;
    int          cyc;
  } uop_exp_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    int          ptr;
  } gnt_exp_t;

  uop_exp_t uq[$];
  gnt_exp_t gq[$];
  bit       rdy_pat[$];
  int       ops_left[N];
  int       n_pass = 0;
  int       n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] mk(input int t, input int w, input int c);
    return 32'hC000_0000 | 32'(t << 8) | 32'(w << 4) | 32'(c);
  endfunction

  task automatic issue(input int w, input int t, input int c, input int n_ops);
    ops_left[w]      = n_ops;
    bus.req_data[w]  = mk(t, w, c);
    bus.req_valid[w] = 1'b1;
  endtask

  // Expected grant at t0 (or any time if t0 < 0) and uops at t0+1.. with ready high.
  task automatic push_op(input int w, input int t0, input int ptr);
    logic [31:0] d;
    int          c;
    d = bus.req_data[w];
    c = int'(d[3:0]);
    gq.push_back('{data: d, cyc: t0, ptr: ptr});
    for (int k = 0; k < c; k++) begin
      uq.push_back('{warp: w, data: d + 32'(k << 16), last: (k == c - 1),
                     cyc: (t0 >= 0) ? t0 + 1 + k : -1});
    end
  endtask

  // One clock: sample pops mid-cycle, update inputs just after the next edge.
  task automatic step();
    logic [N-1:0] rr;
    @(negedge clk);
    rr = bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rr[i] && ops_left[i] > 0) ops_left[i]--;
      bus.req_valid[i] = (ops_left[i] > 0);
    end
    if (rdy_pat.size() > 0) bus.out_ready = rdy_pat.pop_front() ? '1 : '0;
    else bus.out_ready = '1;
  endtask

  function automatic bit any_ops();
    bit r = 1'b0;
    for (int i = 0; i < N; i++) if (ops_left[i] > 0) r = 1'b1;
    return r;
  endfunction

  task automatic run(input string name, input int budget);
    int n = 0;
    while ((busy || any_ops()) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) fail({name, "_timeout"});
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = '1;
    rdy_pat.delete();
    for (int i = 0; i < N; i++) ops_left[i] = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic monitor();
    gnt_exp_t g;
    uop_exp_t u;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.eng_start) begin
          if (gq.size() == 0) fail("unexpected_eng_start");
          else begin
            g = gq.pop_front();
            check("grant_data", longint'(bus.eng_data), longint'(g.data));
            if (g.cyc >= 0) check("grant_cycle", longint'(cyc), longint'(g.cyc));
            if (g.ptr >= 0) check("grant_rr_ptr", longint'(dut.rr_ptr_q), longint'(g.ptr));
          end
        end
        if (busy) begin
          check("out_valid_owner_only", longint'(bus.out_valid), longint'(1) << owner);
          check("eng_next_mirror", longint'(bus.eng_next), longint'(bus.out_ready[owner]));
        end
        for (int i = 0; i < N; i++) begin
          if (bus.out_valid[i] && bus.out_ready[i]) begin
            if (uq.size() == 0) fail("unexpected_uop");
            else begin
              u = uq.pop_front();
              check("uop_warp", longint'(i), longint'(u.warp));
              check("uop_data", longint'(bus.out_data), longint'(u.data));
              check("uop_req_ready", longint'(bus.req_ready[i]), longint'(u.last));
              if (u.cyc >= 0) check("uop_cycle", longint'(cyc), longint'(u.cyc));
            end
          end else if (bus.req_ready[i]) begin
            fail("req_ready_without_accept");
          end
        end
      end
    end
  endtask

  initial begin
    int t0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = '1;
    for (int i = 0; i < N; i++) ops_left[i] = 0;
    fork
      monitor();
    join_none

    // Reset state, including start masked while requests are pending.
    #12;
    bus.req_valid = '1;
    #1;
    check("rst_eng_start", longint'(bus.eng_start), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_req_ready", longint'(bus.req_ready), 0);
    check("rst_eng_next", longint'(bus.eng_next), 0);
    check("rst_owner", longint'(owner), 0);
    check("rst_perf", longint'({perf_macro_ops, perf_stall_cycles}), 0);
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single 3-uop request from warp 0.
    issue(0, 1, 3, 1);
    push_op(0, cyc, 0);
    run("single", 20);
    check("single_macro_ops", longint'(perf_macro_ops), 1);

    // Backpressure on warp 1: ready 1,0,0,1,1 accepts uops at T+1, T+4, T+5.
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    issue(1, 3, 3, 1);
    t0 = cyc;
    gq.push_back('{data: bus.req_data[1], cyc: t0, ptr: 1});
    uq.push_back('{warp: 1, data: bus.req_data[1], last: 1'b0, cyc: t0 + 1});
    uq.push_back('{warp: 1, data: bus.req_data[1] + 32'h1_0000, last: 1'b0, cyc: t0 + 4});
    uq.push_back('{warp: 1, data: bus.req_data[1] + 32'h2_0000, last: 1'b1, cyc: t0 + 5});
    run("backpressure", 30);
    check("bp_stall_cycles", longint'(perf_stall_cycles), 2);
    check("bp_macro_ops", longint'(perf_macro_ops), 2);

    // Move the pointer to 3, then requests 1001: warp 3 first, then warp 0.
    issue(2, 4, 1, 1);
    push_op(2, -1, 2);
    run("ptr_prep", 20);
    check("ptr_prep_rr_ptr", longint'(dut.rr_ptr_q), 3);
    issue(0, 5, 2, 1);
    issue(3, 5, 2, 1);
    push_op(3, -1, 3);
    push_op(0, -1, 0);
    run("ptr_wrap", 30);
    check("ptr_wrap_rr_ptr", longint'(dut.rr_ptr_q), 1);

    // Reset during uop 2 of 4; the same request is re-granted afterwards.
    issue(0, 6, 4, 1);
    t0 = cyc;
    gq.push_back('{data: bus.req_data[0], cyc: t0, ptr: 1});
    uq.push_back('{warp: 0, data: bus.req_data[0], last: 1'b0, cyc: t0 + 1});
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_out_valid", longint'(bus.out_valid), 0);
    check("midrst_req_ready", longint'(bus.req_ready), 0);
    check("midrst_eng_start", longint'(bus.eng_start), 0);
    check("midrst_owner_ptr", longint'({owner, dut.rr_ptr_q}), 0);
    check("midrst_perf", longint'({perf_macro_ops, perf_stall_cycles}), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push_op(0, cyc, 0);
    run("midrst_regrant", 30);
    check("midrst_macro_ops", longint'(perf_macro_ops), 1);

    // Fairness: all four warps, 2 macro-ops each of 2 uops.
    do_reset();
    for (int i = 0; i < N; i++) issue(i, 7, 2, 2);
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_op(i, -1, i);
    run("fairness", 100);
    check("fair_macro_ops", longint'(perf_macro_ops), 8);
    check("fair_stall_cycles", longint'(perf_stall_cycles), 0);

    // Back-to-back single-uop ops: completions at T+1 and T+3.
    do_reset();
    issue(0, 8, 1, 1);
    issue(1, 8, 1, 1);
    t0 = cyc;
    push_op(0, t0, 0);
    push_op(1, t0 + 2, 1);
    run("b2b", 20);
    check("b2b_macro_ops", longint'(perf_macro_ops), 2);

    check("uop_queue_drained", longint'(uq.size()), 0);
    check("grant_queue_drained", longint'(gq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
